// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous data memory between
// the CPU data port (port 0) and the loader/debug port (port 1).
// One transaction at a time: accept (IDLE) -> drive memory (ISSUE) ->
// respond (WAIT), giving one access every three cycles.
// Build option: define ARB_FIXED_PRIO_EN to make port 0 win every tie;
// by default ties are resolved round-robin against the last grant.
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned ST_W = 2;
  localparam int unsigned OFS_W = 2;

  localparam logic [ST_W-1:0] S_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] S_ISSUE = 2'd1;
  localparam logic [ST_W-1:0] S_WAIT  = 2'd2;

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   state_nxt;

  // Latched transaction, captured at acceptance.
  logic              issue_port;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  logic              grant1;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] sel_addr_aligned;
  logic [DATA_W-1:0] sel_wdata;

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: port 1 only wins when port 0 is idle.
  always_comb begin
    grant1 = req1_valid & ~req0_valid;
  end
`else
  logic last_grant;

  // Round-robin: on a tie, the port that did not win last time is granted.
  always_comb begin
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  // Remember the winner of each acceptance; reset favours port 0 next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end
`endif

  // Select the payload of the port currently holding the grant.
  always_comb begin
    sel_we           = grant1 ? req1_we    : req0_we;
    sel_addr         = grant1 ? req1_addr  : req0_addr;
    sel_wdata        = grant1 ? req1_wdata : req0_wdata;
    sel_addr_aligned = {sel_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the accepted request; byte offset is dropped so accesses stay word-aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_port  <= 1'b0;
      issue_we    <= 1'b0;
      issue_addr  <= '0;
      issue_wdata <= '0;
    end else if (accept) begin
      issue_port  <= grant1;
      issue_we    <= sel_we;
      issue_addr  <= sel_addr_aligned;
      issue_wdata <= sel_wdata;
    end
  end

  // Next-state and output decode; every output idles at zero outside its state.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_rdata  = '0;
    case (state)
      S_IDLE: begin
        if (reset) begin
          req0_ready = req0_valid & ~grant1;
          req1_ready = grant1;
          accept     = req0_valid | req1_valid;
        end
        if (accept) begin
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = issue_we;
        mem_addr  = issue_addr;
        mem_wdata = issue_wdata;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        rsp0_valid = ~issue_port;
        rsp1_valid = issue_port;
        if (!issue_we) begin
          rsp_rdata = mem_rdata;
        end
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus for mem_port_arbiter,
// checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_we = 1'b0, req1_we = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_wdata = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached memory device: 16 words, one-cycle read latency.
  bit [31:0] dev_mem [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dev_mem[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= dev_mem[mem_addr[5:2]];
    end
  end

  // Reference model: memory contents plus the one outstanding transaction.
  bit [31:0] ref_mem [16];
  int        cyc = 0;
  bit        pend = 1'b0;
  int        acc_cyc = 0;
  bit        p_port, p_we;
  bit [31:0] p_addr, p_wdata;
  bit        last = 1'b1;
  bit        acc0, acc1;
  int        n_checks = 0, n_fail = 0;
  int        rsp0_cnt = 0, rsp1_cnt = 0, en_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Compare all outputs at the falling edge, then advance the model.
  task automatic check_cycle();
    bit busy, w0, w1, en_e, rsp_e;
    @(negedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    w0 = 1'b0;
    w1 = 1'b0;
    if (!reset) begin
      pend = 1'b0;
      last = 1'b1;
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    end
    busy = pend && (cyc < acc_cyc + 3);
    if (reset && !busy) begin
      if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
        w0 = 1'b1;
`else
        if (last) w0 = 1'b1;
        else      w1 = 1'b1;
`endif
      end else begin
        w0 = req0_valid;
        w1 = req1_valid;
      end
    end
    en_e  = reset && pend && (cyc == acc_cyc + 1);
    rsp_e = reset && pend && (cyc == acc_cyc + 2);
    chk("ready0", 32'(req0_ready), 32'(w0));
    chk("ready1", 32'(req1_ready), 32'(w1));
    chk("mem_en", 32'(mem_en), 32'(en_e));
    if (en_e) begin
      chk("mem_we", 32'(mem_we), 32'(p_we));
      chk("mem_addr", mem_addr, p_addr & ~32'h3);
      if (p_we) begin
        chk("mem_wdata", mem_wdata, p_wdata);
        ref_mem[p_addr[5:2]] = p_wdata;
      end
    end
    chk("rsp0_valid", 32'(rsp0_valid), 32'(rsp_e && !p_port));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(rsp_e && p_port));
    if (rsp_e) chk("rsp_rdata", rsp_rdata, p_we ? 32'h0 : ref_mem[p_addr[5:2]]);
    if (rsp0_valid) rsp0_cnt++;
    if (rsp1_valid) rsp1_cnt++;
    if (mem_en) en_cnt++;
    if (w0 || w1) begin
      pend    = 1'b1;
      acc_cyc = cyc;
      p_port  = w1;
      last    = w1;
      p_we    = w1 ? req1_we : req0_we;
      p_addr  = w1 ? req1_addr : req0_addr;
      p_wdata = w1 ? req1_wdata : req0_wdata;
      acc0    = w0;
      acc1    = w1;
    end
  endtask

  task automatic tick();
    check_cycle();
    next_cycle();
  endtask

  task automatic drive(input bit port, input bit v, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (port) begin
      req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end
  endtask

  // One complete transaction on a single port; returns what was seen at issue and response.
  task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] o_addr,
                         output logic o_we, output logic o_rsp, output logic [31:0] o_rdata);
    bit done = 1'b0;
    drive(port, 1'b1, we, addr, wdata);
    for (int i = 0; i < 20 && !done; i++) begin
      check_cycle();
      done = port ? acc1 : acc0;
      next_cycle();
    end
    if (!done) chk("txn_timeout", 32'(0), 32'(1));
    drive(port, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    o_addr = mem_addr;
    o_we   = mem_we;
    next_cycle();
    check_cycle();
    o_rsp   = port ? rsp1_valid : rsp0_valid;
    o_rdata = rsp_rdata;
    next_cycle();
  endtask

  logic [31:0] t_addr, t_rdata;
  logic        t_we, t_rsp;
  int          base;
  int          g_cyc[$];
  bit          g_port[$];
  bit          hold[2];
  bit          rv[2], rwe[2];
  bit [31:0]   raddr[2], rwd[2];

  initial begin
    // Reset phase: every output must read zero.
    repeat (2) tick();
    chk("rst_ready0", 32'(req0_ready), 32'(0));
    chk("rst_rsp0", 32'(rsp0_valid), 32'(0));
    reset = 1'b1;
    tick();

    // Seed word 0x10, then single load from port 0.
    run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, t_addr, t_we, t_rsp, t_rdata);
    chk("seed_we", 32'(t_we), 32'(1));
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    check_cycle();
    chk("load_ready0", 32'(req0_ready), 32'(1));
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    chk("load_en", 32'(mem_en), 32'(1));
    chk("load_we", 32'(mem_we), 32'(0));
    chk("load_addr", mem_addr, 32'h10);
    next_cycle();
    check_cycle();
    chk("load_rsp0", 32'(rsp0_valid), 32'(1));
    chk("load_rdata", rsp_rdata, 32'hDEADBEEF);
    next_cycle();

    // Store then load on port 1.
    base = rsp1_cnt;
    run_txn(1'b1, 1'b1, 32'h20, 32'h12345678, t_addr, t_we, t_rsp, t_rdata);
    chk("st1_we", 32'(t_we), 32'(1));
    chk("st1_rsp", 32'(t_rsp), 32'(1));
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, t_addr, t_we, t_rsp, t_rdata);
    chk("ld1_rdata", t_rdata, 32'h12345678);
    chk("rsp1_pulses", 32'(rsp1_cnt - base), 32'(2));

    // Misaligned store, then read back aligned.
    run_txn(1'b0, 1'b1, 32'h23, 32'hA5A5A5A5, t_addr, t_we, t_rsp, t_rdata);
    chk("mis_addr", t_addr, 32'h20);
    chk("mis_rsp", 32'(t_rsp), 32'(1));
    chk("mis_rdata", t_rdata, 32'h0);
    run_txn(1'b0, 1'b0, 32'h20, 32'h0, t_addr, t_we, t_rsp, t_rdata);
    chk("mis_readback", t_rdata, 32'hA5A5A5A5);

    // Withdrawn request on port 1 while port 0 owns the memory.
    base = rsp1_cnt;
    en_cnt = 0;
    drive(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h4, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) tick();
    chk("wd_rsp1", 32'(rsp1_cnt - base), 32'(0));
    chk("wd_mem_en", 32'(en_cnt), 32'(1));

    // Reset during ISSUE; port 0 won last so round-robin alone would favour port 1.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check_cycle();
    chk("rr_en_before", 32'(mem_en), 32'(1));
    #1 reset = 1'b0;
    #1 chk("rr_en_async", 32'(mem_en), 32'(0));
    next_cycle();
    check_cycle();
    next_cycle();
    reset = 1'b1;
    base = rsp0_cnt + rsp1_cnt;
    repeat (3) tick();
    chk("rr_no_rsp", 32'(rsp0_cnt + rsp1_cnt - base), 32'(0));

    // Continuous contention for 12 cycles, starting right after reset.
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 12; i++) begin
      check_cycle();
      if (req0_ready) begin g_cyc.push_back(i); g_port.push_back(1'b0); end
      if (req1_ready) begin g_cyc.push_back(i); g_port.push_back(1'b1); end
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) tick();
    chk("cont_count", 32'(g_cyc.size()), 32'(4));
    for (int k = 0; k < 4 && k < g_cyc.size(); k++) begin
      chk($sformatf("cont_cycle%0d", k), 32'(g_cyc[k]), 32'(3 * k));
`ifdef ARB_FIXED_PRIO_EN
      chk($sformatf("cont_port%0d", k), 32'(g_port[k]), 32'(0));
`else
      chk($sformatf("cont_port%0d", k), 32'(g_port[k]), 32'(k % 2));
`endif
    end

    // Random traffic with occasional resets and withdrawals.
    hold[0] = 1'b0;
    hold[1] = 1'b0;
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < 2; p++) begin
        if ((p == 0 && acc0) || (p == 1 && acc1)) hold[p] = 1'b0;
        if (hold[p]) begin
          if ($urandom_range(0, 7) == 0) begin
            hold[p] = 1'b0;
            rv[p] = 1'b0;
          end
        end else if ($urandom_range(0, 1) == 1) begin
          hold[p]  = 1'b1;
          rv[p]    = 1'b1;
          rwe[p]   = 1'($urandom_range(0, 1));
          raddr[p] = 32'($urandom_range(0, 63));
          rwd[p]   = $urandom;
        end else begin
          rv[p] = 1'b0;
        end
        drive(p[0], rv[p], rwe[p], raddr[p], rwd[p]);
      end
      tick();
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
